time_of_day_counter: RTL and testbench

Time-keeping core of the digital clock: consumes the divided clock output `clk_1hz` and maintains hours, minutes and seconds as BCD digits for the display stage. It runs entirely on the main clock, derives a one-cycle seconds tick from the rising edge of `clk_1hz`, and provides a set mode for hours and minutes driven by two pre-debounced button pulses.

---
 rtl/time_of_day_counter_if.sv | 49 ++++
 rtl/time_of_day_counter.sv | 173 +++++++++++++++++
 tb/tb_time_of_day_counter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_of_day_counter_if.sv
// Time-of-day counter bus: seconds strobe and buttons in,
// BCD time digits, mode and status pulses out.
interface time_of_day_counter_if;
  logic       clk_1hz;
  logic       mode_btn;
  logic       inc_btn;
  logic [1:0] hour_tens;
  logic [3:0] hour_units;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       pm;
  logic [1:0] mode;
  logic       sec_tick;
  logic       day_pulse;

  modport master (
    output clk_1hz,
    output mode_btn,
    output inc_btn,
    input  hour_tens,
    input  hour_units,
    input  min_tens,
    input  min_units,
    input  sec_tens,
    input  sec_units,
    input  pm,
    input  mode,
    input  sec_tick,
    input  day_pulse
  );

  modport slave (
    input  clk_1hz,
    input  mode_btn,
    input  inc_btn,
    output hour_tens,
    output hour_units,
    output min_tens,
    output min_units,
    output sec_tens,
    output sec_units,
    output pm,
    output mode,
    output sec_tick,
    output day_pulse
  );
endinterface

// File: rtl/time_of_day_counter.sv
// BCD hours/minutes/seconds counter with RUN / SET_HOUR / SET_MIN
// modes, advanced by rising edges of a same-clock 1 Hz strobe.
module time_of_day_counter #(
  parameter bit HOUR_24 = 1'b1
) (
  input  logic clk,
  input  logic reset,
  time_of_day_counter_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_e;

  localparam logic [1:0] HT_RST = HOUR_24 ? 2'd0 : 2'd1;
  localparam logic [3:0] HU_RST = HOUR_24 ? 4'd0 : 4'd2;

  mode_e      mode_q, mode_d;
  logic       clk_1hz_q;
  logic [1:0] ht_q, ht_d;
  logic [3:0] hu_q, hu_d;
  logic [2:0] mt_q, mt_d;
  logic [3:0] mu_q, mu_d;
  logic [2:0] st_q, st_d;
  logic [3:0] su_q, su_d;
  logic       pm_q, pm_d;
  logic       sec_tick_q, sec_tick_d;
  logic       day_q, day_d;
  logic       tick;
  logic       last_hour;
  logic       sec_wrap;
  logic       min_wrap;

  // {tens[2:0], units[3:0]} counting 00..59
  function automatic logic [6:0] inc_ms(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[6:4] == 3'd5) r = 7'd0;
      else r = {v[6:4] + 3'd1, 4'd0};
    end else begin
      r = {v[6:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // {pm, tens[1:0], units[3:0]}
  function automatic logic [6:0] inc_hr(input logic [6:0] v);
    logic       p;
    logic [1:0] t;
    logic [3:0] u;
    {p, t, u} = v;
    if (HOUR_24) begin
      if (t == 2'd2 && u == 4'd3) begin
        t = 2'd0;
        u = 4'd0;
      end else if (u == 4'd9) begin
        t = t + 2'd1;
        u = 4'd0;
      end else begin
        u = u + 4'd1;
      end
    end else begin
      if (t == 2'd1 && u == 4'd2) begin
        t = 2'd0;
        u = 4'd1;
      end else if (t == 2'd1 && u == 4'd1) begin
        u = 4'd2;
        p = ~p;
      end else if (u == 4'd9) begin
        t = 2'd1;
        u = 4'd0;
      end else begin
        u = u + 4'd1;
      end
    end
    return {p, t, u};
  endfunction

  assign tick     = bus.clk_1hz & ~clk_1hz_q;
  assign sec_wrap = ({st_q, su_q} == 7'h59);
  assign min_wrap = ({mt_q, mu_q} == 7'h59);
  assign last_hour = HOUR_24
    ? (ht_q == 2'd2 && hu_q == 4'd3)
    : (pm_q && ht_q == 2'd1 && hu_q == 4'd1);

  always_comb begin
    mode_d     = mode_q;
    ht_d       = ht_q;
    hu_d       = hu_q;
    mt_d       = mt_q;
    mu_d       = mu_q;
    st_d       = st_q;
    su_d       = su_q;
    pm_d       = pm_q;
    sec_tick_d = 1'b0;
    day_d      = 1'b0;
    unique case (mode_q)
      RUN: begin
        if (bus.mode_btn) mode_d = SET_HOUR;
        // a tick on the same edge we leave RUN still counts
        if (tick) begin
          sec_tick_d   = 1'b1;
          {st_d, su_d} = inc_ms({st_q, su_q});
          if (sec_wrap) begin
            {mt_d, mu_d} = inc_ms({mt_q, mu_q});
            if (min_wrap) begin
              {pm_d, ht_d, hu_d} = inc_hr({pm_q, ht_q, hu_q});
              day_d = last_hour;
            end
          end
        end
      end
      SET_HOUR: begin
        if (bus.mode_btn) mode_d = SET_MIN;
        else if (bus.inc_btn)
          {pm_d, ht_d, hu_d} = inc_hr({pm_q, ht_q, hu_q});
      end
      SET_MIN: begin
        // restart on a minute boundary; a coincident tick is dropped
        if (bus.mode_btn) begin
          mode_d = RUN;
          st_d   = 3'd0;
          su_d   = 4'd0;
        end else if (bus.inc_btn) begin
          {mt_d, mu_d} = inc_ms({mt_q, mu_q});
        end
      end
      default: mode_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= RUN;
      clk_1hz_q  <= 1'b0;
      ht_q       <= HT_RST;
      hu_q       <= HU_RST;
      mt_q       <= 3'd0;
      mu_q       <= 4'd0;
      st_q       <= 3'd0;
      su_q       <= 4'd0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      day_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      clk_1hz_q  <= bus.clk_1hz;
      ht_q       <= ht_d;
      hu_q       <= hu_d;
      mt_q       <= mt_d;
      mu_q       <= mu_d;
      st_q       <= st_d;
      su_q       <= su_d;
      pm_q       <= pm_d;
      sec_tick_q <= sec_tick_d;
      day_q      <= day_d;
    end
  end

  assign bus.hour_tens  = ht_q;
  assign bus.hour_units = hu_q;
  assign bus.min_tens   = mt_q;
  assign bus.min_units  = mu_q;
  assign bus.sec_tens   = st_q;
  assign bus.sec_units  = su_q;
  assign bus.pm         = pm_q;
  assign bus.mode       = mode_q;
  assign bus.sec_tick   = sec_tick_q;
  assign bus.day_pulse  = day_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench: 24h and 12h counters driven in lockstep and
// checked every cycle against a seconds-of-day reference model.
module tb_time_of_day_counter;

  logic clk = 1'b0;
  logic reset;
  logic c1_drv, mb_drv, ib_drv;

  always #5 clk = ~clk;

  time_of_day_counter_if b24 ();
  time_of_day_counter_if b12 ();

  assign b24.clk_1hz  = c1_drv;
  assign b24.mode_btn = mb_drv;
  assign b24.inc_btn  = ib_drv;
  assign b12.clk_1hz  = c1_drv;
  assign b12.mode_btn = mb_drv;
  assign b12.inc_btn  = ib_drv;

  time_of_day_counter #(.HOUR_24(1'b1)) dut24 (
    .clk(clk), .reset(reset), .bus(b24.slave)
  );
  time_of_day_counter #(.HOUR_24(1'b0)) dut12 (
    .clk(clk), .reset(reset), .bus(b12.slave)
  );

  typedef struct packed {
    logic [24:0] e24;
    logic [24:0] e12;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   n_total = 0;
  int   n_pass  = 0;

  // reference state: canonical 0..23 hour, mode 0/1/2
  int mh, mm, ms, mmode;
  bit mprev;
  bit lvl;

  function automatic logic [24:0] disp(
    input bit h24, input int h, input int m, input int s,
    input int md, input bit tk, input bit dy);
    int hd;
    bit p;
    hd = h;
    p  = 1'b0;
    if (!h24) begin
      hd = (h % 12 == 0) ? 12 : h % 12;
      p  = (h >= 12);
    end
    return {2'(hd / 10), 4'(hd % 10), 3'(m / 10), 4'(m % 10),
            3'(s / 10), 4'(s % 10), p, 2'(md), tk, dy};
  endfunction

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mmode = 0; mprev = 1'b0;
  endtask

  task automatic push_exp(input bit tk, input bit dy);
    exp_t e;
    e.e24 = disp(1'b1, mh, mm, ms, mmode, tk, dy);
    e.e12 = disp(1'b0, mh, mm, ms, mmode, tk, dy);
    q.push_back(e);
  endtask

  task automatic step(input bit r, input bit c, input bit mb, input bit ib);
    bit tk, dy, tk_in;
    int tot;
    @(negedge clk);
    reset = r; c1_drv = c; mb_drv = mb; ib_drv = ib;
    tk = 1'b0; dy = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      tk_in = c && !mprev;
      mprev = c;
      case (mmode)
        0: begin
          if (tk_in) begin
            tk  = 1'b1;
            tot = mh * 3600 + mm * 60 + ms + 1;
            if (tot == 86400) begin
              dy  = 1'b1;
              tot = 0;
            end
            mh = tot / 3600;
            mm = (tot / 60) % 60;
            ms = tot % 60;
          end
          if (mb) mmode = 1;
        end
        1: begin
          if (mb) mmode = 2;
          else if (ib) mh = (mh + 1) % 24;
        end
        default: begin
          if (mb) begin
            mmode = 0;
            ms    = 0;
          end else if (ib) begin
            mm = (mm + 1) % 60;
          end
        end
      endcase
    end
    push_exp(tk, dy);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, lvl, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      lvl = 1'b1;
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b1, 1'b0, 1'b0);
      lvl = 1'b0;
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic press_mode();
    step(1'b0, lvl, 1'b1, 1'b0);
    step(1'b0, lvl, 1'b0, 1'b0);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin
      lvl = 1'($urandom_range(0, 1));
      step(1'b0, lvl, 1'b0, 1'b1);
      lvl = 1'($urandom_range(0, 1));
      step(1'b0, lvl, 1'b0, 1'b0);
    end
    lvl = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1; c1_drv = 1'b0; mb_drv = 1'b0; ib_drv = 1'b0;
    lvl = 1'b0;
    model_reset();
    push_exp(1'b0, 1'b0);
    push_exp(1'b0, 1'b0);
    -> sample_ev;
  endtask

  task automatic check(input string nm, input logic [24:0] act,
                       input logic [24:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    else
      n_pass++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("dut24", {b24.hour_tens, b24.hour_units, b24.min_tens,
          b24.min_units, b24.sec_tens, b24.sec_units, b24.pm, b24.mode,
          b24.sec_tick, b24.day_pulse}, e.e24);
        check("dut12", {b12.hour_tens, b12.hour_units, b12.min_tens,
          b12.min_units, b12.sec_tens, b12.sec_units, b12.pm, b12.mode,
          b12.sec_tick, b12.day_pulse}, e.e12);
      end
    end
  end

  initial begin
    bit pmb, pib, nmb, nib;
    reset = 1'b1; c1_drv = 1'b0; mb_drv = 1'b0; ib_drv = 1'b0;
    lvl = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // one minute of seconds
    ticks(60);
    idle(3);

    // set 23:59 and roll over midnight
    press_mode();
    press_inc(23);
    press_mode();
    press_inc(58);
    press_mode();
    ticks(60);
    idle(2);

    // 11:59:59 AM -> 12 PM, then 11:59:59 PM -> 12 AM
    press_mode();
    press_inc(11);
    press_mode();
    press_inc(59);
    press_mode();
    ticks(60);
    press_mode();
    press_inc(11);
    press_mode();
    press_inc(59);
    press_mode();
    ticks(60);
    idle(2);

    // hour wrap in set mode, minute wrap, simultaneous buttons
    press_mode();
    press_inc(25);
    press_mode();
    press_inc(59);
    press_inc(1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // tick coincident with leaving RUN, then with entering RUN
    ticks(5);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lvl = 1'b1;
    press_mode();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    lvl = 1'b0;
    idle(2);

    // long high strobe
    lvl = 1'b1;
    idle(1000);
    lvl = 1'b0;
    idle(2);

    // async reset at 00:00:37
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    ticks(37);
    idle(2);
    async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    ticks(3);

    // random traffic
    pmb = 1'b0;
    pib = 1'b0;
    repeat (400) begin
      nmb = !pmb && ($urandom_range(0, 15) == 0);
      nib = !pib && ($urandom_range(0, 3) == 0);
      lvl = 1'($urandom_range(0, 1));
      step(1'b0, lvl, nmb, nib);
      pmb = nmb;
      pib = nib;
    end
    idle(2);

    @(negedge clk);
    #2;
    n_total++;
    if (q.size() != 0)
      $display("FAIL drain t=%0t got %0d pending want 0", $time, q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
